usart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single USART transmitter among `N_REQ` requesters. It accepts byte requests and latches the winning byte. It then drives the transmitter's load/start handshake and holds ownership until the transmitter reports frame completion. The block sits between client logic and the USART Tx datapath, in the `CLK` domain, alongside the baud-clock (`CLK_B`) driven USART.

---
 rtl/usart_pkg.sv | 21 ++
 rtl/rr_picker.sv | 41 ++++
 rtl/usart_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_usart_tx_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usart_pkg.sv
// -----------------------------------------------------------------------------
// usart_pkg
// Shared definitions for the USART transmit-side blocks.
//   arb_state_e          : arbiter FSM encoding (IDLE=0, GRANT=1, START=2,
//                          WAIT_DONE=3)
//   DEFAULT_DATA_W       : default byte width on request and Tx data paths
//   DEFAULT_TIMEOUT_CYC  : default CLK cycles allowed in WAIT_DONE
// -----------------------------------------------------------------------------
package usart_pkg;

    localparam int DEFAULT_DATA_W      = 8;
    localparam int DEFAULT_TIMEOUT_CYC = 200000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT     = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

endpackage : usart_pkg

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector. Scans last+1, last+2, ... with
// wrap-around and returns the first asserted request index.
// Ports:
//   req   [N_REQ-1:0] : request levels
//   last  [IDX_W-1:0] : index of the previous winner (scan starts after it)
//   valid             : at least one request is asserted
//   idx   [IDX_W-1:0] : winning index (0 when valid is low)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Scanning from the farthest candidate down to the nearest lets the
    // nearest asserted request overwrite any earlier hit, so no early exit
    // is needed to get round-robin order.
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment; a path that skips an assignment would infer a latch.
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % N_REQ);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule : rr_picker

// File: rtl/usart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// usart_tx_arbiter
// Round-robin scheduler sharing one USART transmitter among N_REQ requesters.
// Latches the winning byte, issues the load/start strobe once the transmitter
// is idle, and keeps ownership until the frame completes.
//
// Optional feature: define USART_ARB_TIMEOUT_EN to abort a transfer that has
// waited TIMEOUT_CYC cycles for tx_done (pulses timeout_err). Without it,
// timeout_err is tied low and WAIT_DONE waits indefinitely.
//
// Ports:
//   CLK, CLR                : clock, synchronous active-high reset
//   req      [N_REQ-1:0]    : request levels
//   req_data [N_REQ*DATA_W] : requester i's byte at [i*DATA_W +: DATA_W]
//   grant    [N_REQ-1:0]    : one-hot one-cycle acceptance pulse
//   owner                   : index of the current or last owner
//   active                  : high from the grant cycle until back in IDLE
//   tx_data  [DATA_W-1:0]   : byte presented to the transmitter
//   tx_start                : one-cycle start strobe
//   tx_busy, tx_done        : transmitter status / frame-complete pulse
//   timeout_err             : one-cycle pulse on an aborted transfer
// All outputs are registered.
// -----------------------------------------------------------------------------
module usart_tx_arbiter
    import usart_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           grant,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       active,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    input  logic                       tx_done,
    output logic                       timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("usart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic              tx_start_q, tx_start_d;
    logic              active_q, active_d;
    logic              timeout_hit;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        tx_data_d  = tx_data_q;
        grant_d    = '0;
        tx_start_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d           = pick_idx;
                    tx_data_d         = req_data[int'(pick_idx)*DATA_W +: DATA_W];
                    grant_d[pick_idx] = 1'b1;
                    state_d           = GRANT;
                end
            end
            // tx_start is registered, so the strobe is raised on the edge
            // that sees the transmitter idle; START then hands over to
            // WAIT_DONE on the following edge, once the strobe is out.
            GRANT: begin
                state_d    = START;
                tx_start_d = !tx_busy;
            end
            START: begin
                if (tx_start_q) begin
                    state_d = WAIT_DONE;
                end else begin
                    tx_start_d = !tx_busy;
                end
            end
            WAIT_DONE: begin
                // tx_done has priority over a coincident terminal count.
                if (tx_done || timeout_hit) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        active_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        // NOTE: synchronous reset -- CLR is only looked at on the clock edge,
        // so it sits inside the edge-triggered block, not in the sensitivity list.
        if (CLR) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_q     <= IDX_W'(N_REQ - 1);
            tx_data_q  <= '0;
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state so every flop
            // samples the pre-edge values regardless of statement order.
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            tx_start_q <= tx_start_d;
            active_q   <= active_d;
        end
    end

`ifdef USART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;

    // The counter is held at zero outside WAIT_DONE, so it is already clear
    // on entry. The abort fires on the edge that would take it to
    // TIMEOUT_CYC, i.e. exactly TIMEOUT_CYC cycles after entry.
    always_comb begin
        cnt_d         = (state_q == WAIT_DONE) ? cnt_q + 1'b1 : '0;
        timeout_hit   = (state_q == WAIT_DONE) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
        timeout_err_d = timeout_hit && !tx_done;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign grant    = grant_q;
    assign owner    = owner_q;
    assign active   = active_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;

endmodule : usart_tx_arbiter

// File: tb/tb_usart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_usart_tx_arbiter
// Directed bench for usart_tx_arbiter (N_REQ=4, DATA_W=8, TIMEOUT_CYC=50).
// Inputs change and outputs are read 1 ns after each rising edge.
// Honors USART_ARB_TIMEOUT_EN the same way the RTL does.
// -----------------------------------------------------------------------------
module tb_usart_tx_arbiter;

    localparam int N_REQ       = 4;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 50;
`ifdef USART_ARB_TIMEOUT_EN
    localparam int DONE_DLY    = 30;
`else
    localparam int DONE_DLY    = 1000;
`endif

    logic                    CLK = 1'b0;
    logic                    CLR;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        grant;
    logic [1:0]              owner;
    logic                    active;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_start;
    logic                    tx_busy;
    logic                    tx_done;
    logic                    timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    usart_tx_arbiter #(
        .N_REQ       (N_REQ),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .CLK         (CLK),
        .CLR         (CLR),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .owner       (owner),
        .active      (active),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_grant(input int max_cyc);
        int n = 0;
        while (grant == '0 && n < max_cyc) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_start(input int max_cyc);
        int n = 0;
        while (!tx_start && n < max_cyc) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_done;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // Full transfer: grant -> tx_start -> WAIT_DONE -> tx_done after dly cycles.
    task automatic do_xfer(input string tag, input int idx, input logic [7:0] data, input int dly);
        wait_grant(20);
        check({tag, "_grant"}, 32'(grant), 32'(1 << idx));
        check({tag, "_owner"}, 32'(owner), 32'(idx));
        check({tag, "_data"}, 32'(tx_data), 32'(data));
        tick();
        wait_start(20);
        check({tag, "_start"}, 32'(tx_start), 32'd1);
        tick();
        repeat (dly - 1) tick();
        pulse_done();
        check({tag, "_idle"}, 32'(active), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   n;

        CLR      = 1'b1;
        req      = '0;
        req_data = '0;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;

        // ---------------- reset and single request ----------------
        repeat (5) tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);

        CLR           = 1'b0;
        req           = 4'b0001;
        req_data[7:0] = 8'h09;
        tick();
        check("t1_grant", 32'(grant), 32'b0001);
        check("t1_owner", 32'(owner), 32'd0);
        check("t1_tx_data", 32'(tx_data), 32'h09);
        check("t1_active", 32'(active), 32'd1);
        check("t1_no_start_in_grant", 32'(tx_start), 32'd0);
        req = '0;
        tick();
        check("t1_tx_start", 32'(tx_start), 32'd1);
        check("t1_no_grant_in_start", 32'(grant), 32'd0);
        tick();
        check("t1_start_once", 32'(tx_start), 32'd0);
        repeat (DONE_DLY - 1) tick();
        check("t1_active_wait", 32'(active), 32'd1);
        pulse_done();
        check("t1_idle", 32'(active), 32'd0);
        check("t1_data_hold", 32'(tx_data), 32'h09);

        // stray tx_done in IDLE
        pulse_done();
        tick();
        check("stray_idle_active", 32'(active), 32'd0);
        check("stray_idle_grant", 32'(grant), 32'd0);

        // ---------------- round-robin fairness ----------------
        CLR = 1'b1;
        tick();
        CLR      = 1'b0;
        req      = 4'b1111;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 5; i++) begin
            do_xfer($sformatf("rr%0d", i), i % 4, 8'hA0 + 8'(i % 4), 5);
        end
        req = '0;

        // ---------------- busy stall (and stray tx_done in START) ----------------
        tx_busy         = 1'b1;
        req             = 4'b0100;
        req_data[23:16] = 8'h5C;
        wait_grant(20);
        check("busy_grant", 32'(grant), 32'b0100);
        check("busy_data", 32'(tx_data), 32'h5C);
        req = '0;
        tick();
        seen = tx_start;
        for (int i = 0; i < 20; i++) begin
            tx_done = (i == 5);
            tick();
            seen |= tx_start;
        end
        tx_done = 1'b0;
        check("busy_no_start", 32'(seen), 32'd0);
        check("busy_active", 32'(active), 32'd1);
        tx_busy = 1'b0;
        tick();
        check("busy_start", 32'(tx_start), 32'd1);
        tick();
        check("busy_start_once", 32'(tx_start), 32'd0);
        check("busy_wait_active", 32'(active), 32'd1);
        repeat (3) tick();
        pulse_done();
        check("busy_idle", 32'(active), 32'd0);

        // ---------------- reset mid-operation ----------------
        req           = 4'b0001;
        req_data[7:0] = 8'h11;
        wait_grant(20);
        check("mid_grant", 32'(grant), 32'b0001);
        req = '0;
        tick();
        wait_start(20);
        tick();
        repeat (3) tick();
        check("mid_active_before", 32'(active), 32'd1);
        CLR = 1'b1;
        tick();
        check("mid_rst_active", 32'(active), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_owner", 32'(owner), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_tx_start", 32'(tx_start), 32'd0);
        check("mid_rst_timeout", 32'(timeout_err), 32'd0);
        CLR             = 1'b0;
        req             = 4'b0100;
        req_data[23:16] = 8'h77;
        tick();
        check("mid_regrant", 32'(grant), 32'b0100);
        check("mid_regrant_owner", 32'(owner), 32'd2);
        check("mid_regrant_data", 32'(tx_data), 32'h77);
        req = '0;
        tick();
        wait_start(20);
        tick();
        repeat (2) tick();
        pulse_done();
        check("mid_idle", 32'(active), 32'd0);

        // ---------------- timeout ----------------
        req           = 4'b0001;
        req_data[7:0] = 8'h21;
        wait_grant(20);
        check("to_grant", 32'(grant), 32'b0001);
        req = '0;
        tick();
        wait_start(20);
        check("to_start", 32'(tx_start), 32'd1);
        tick();
        req            = 4'b0010;
        req_data[15:8] = 8'h42;
`ifdef USART_ARB_TIMEOUT_EN
        n = 0;
        while (!timeout_err && n < 100) begin
            tick();
            n++;
        end
        check("to_latency", 32'(n), 32'd50);
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_idle", 32'(active), 32'd0);
        tick();
        check("to_err_once", 32'(timeout_err), 32'd0);
        check("to_next_grant", 32'(grant), 32'b0010);
        check("to_next_data", 32'(tx_data), 32'h42);
        req = '0;
        tick();
        wait_start(20);
        tick();
        repeat (TIMEOUT_CYC - 1) tick();
        pulse_done();
        check("edge_done_no_err", 32'(timeout_err), 32'd0);
        check("edge_done_idle", 32'(active), 32'd0);
`else
        n    = 0;
        seen = 1'b0;
        repeat (60) begin
            tick();
            seen |= timeout_err;
            n++;
        end
        check("noto_no_err", 32'(seen), 32'd0);
        check("noto_active", 32'(active), 32'd1);
        check("noto_cycles", 32'(n), 32'd60);
        pulse_done();
        check("noto_idle", 32'(active), 32'd0);
        tick();
        check("noto_next_grant", 32'(grant), 32'b0010);
        req = '0;
        tick();
        wait_start(20);
        tick();
        repeat (4) tick();
        pulse_done();
        check("noto_next_idle", 32'(active), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_usart_tx_arbiter
